// File: rtl/seg_scan_driver_pkg.sv
// Shared constants, digit slot encodings and code helpers for the 7-segment scan driver.
package seg_scan_driver_pkg;

  localparam int unsigned VAL_W = 6;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned SEG_W = 8;
  localparam int unsigned SEL_W = 8;

  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;
  localparam logic [SEG_W-1:0] SEG_DASH  = 8'h40;

  // Scan slot order is M_U -> M_T -> P_U -> P_T -> M_U.
  typedef enum logic [1:0] {
    IDX_M_U = 2'd0,
    IDX_M_T = 2'd1,
    IDX_P_U = 2'd2,
    IDX_P_T = 2'd3
  } idx_e;

  // {dp,g,f,e,d,c,b,a}; dp is never lit.
  function automatic logic [SEG_W-1:0] digit_code(input logic [DIG_W-1:0] d);
    case (d)
      4'd0:    return 8'h3F;
      4'd1:    return 8'h06;
      4'd2:    return 8'h5B;
      4'd3:    return 8'h4F;
      4'd4:    return 8'h66;
      4'd5:    return 8'h6D;
      4'd6:    return 8'h7D;
      4'd7:    return 8'h07;
      4'd8:    return 8'h7F;
      4'd9:    return 8'h6F;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Physical enable for each slot; bank positions 2..5 are unused.
  function automatic logic [SEL_W-1:0] sel_code(input idx_e idx);
    case (idx)
      IDX_M_U: return 8'h01;
      IDX_M_T: return 8'h02;
      IDX_P_U: return 8'h40;
      IDX_P_T: return 8'h80;
      default: return 8'h01;
    endcase
  endfunction

  function automatic idx_e next_idx(input idx_e idx);
    case (idx)
      IDX_M_U: return IDX_M_T;
      IDX_M_T: return IDX_P_U;
      IDX_P_U: return IDX_P_T;
      IDX_P_T: return IDX_M_U;
      default: return IDX_M_U;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_driver_bcd_split.sv
// Splits a 0..63 countdown into decimal tens/units; values 60..63 flag overflow.
module seg_scan_driver_bcd_split
  import seg_scan_driver_pkg::*;
(
  input  logic [VAL_W-1:0] v,
  output logic [DIG_W-1:0] tens,
  output logic [DIG_W-1:0] units,
  output logic             ovf
);

  always_comb begin
    tens  = '0;
    units = '0;
    ovf   = (v >= VAL_W'(60));
    if (!ovf) begin
      tens  = DIG_W'(v / VAL_W'(10));
      units = DIG_W'(v % VAL_W'(10));
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit 7-seg scan for pedestrian/main countdowns with frame-synchronous
// double buffering, anti-ghost dead time, leading-zero blanking and per-pair blink.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int unsigned CNT_DIS   = 25_000,
  parameter int unsigned DEAD      = 250,
  parameter int unsigned CNT_BLINK = 50_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [VAL_W-1:0] p_cnt,
  input  logic [VAL_W-1:0] m_cnt,
  input  logic             load,
  input  logic             blink_p,
  input  logic             blink_m,
  input  logic             blank_lz,
  output logic [SEL_W-1:0] sel,
  output logic [SEG_W-1:0] seg,
  output logic             frame_done
);

  localparam int unsigned SLOT_W  = $clog2(CNT_DIS + 1);
  localparam int unsigned BLINK_W = $clog2(CNT_BLINK + 1);

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(CNT_DIS);
  localparam logic [SLOT_W-1:0]  SLOT_PRE   = SLOT_W'(CNT_DIS - 1);
  localparam logic [SLOT_W-1:0]  DEAD_START = SLOT_W'(CNT_DIS - DEAD);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(CNT_BLINK);

  logic [SLOT_W-1:0]  slot_cnt, slot_cnt_nxt;
  idx_e               idx, idx_nxt;
  logic [VAL_W-1:0]   shadow_p, shadow_p_nxt;
  logic [VAL_W-1:0]   shadow_m, shadow_m_nxt;
  logic [VAL_W-1:0]   act_p, act_p_nxt;
  logic [VAL_W-1:0]   act_m, act_m_nxt;
  logic [BLINK_W-1:0] blink_cnt, blink_cnt_nxt;
  logic               blink_hide, blink_hide_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic [SEG_W-1:0]   seg_nxt;
  logic               frame_done_nxt;

  logic               slot_end;
  logic               wrap;
  logic               pair_p;
  logic               is_tens;
  logic               pair_ovf;
  logic               pair_blink;
  logic [DIG_W-1:0]   digit;

  logic [DIG_W-1:0]   p_tens, p_units, m_tens, m_units;
  logic               p_ovf, m_ovf;

  seg_scan_driver_bcd_split u_bcd_p (
    .v     (act_p),
    .tens  (p_tens),
    .units (p_units),
    .ovf   (p_ovf)
  );

  seg_scan_driver_bcd_split u_bcd_m (
    .v     (act_m),
    .tens  (m_tens),
    .units (m_units),
    .ovf   (m_ovf)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      slot_cnt   <= '0;
      idx        <= IDX_M_U;
      shadow_p   <= '0;
      shadow_m   <= '0;
      act_p      <= '0;
      act_m      <= '0;
      blink_cnt  <= '0;
      blink_hide <= 1'b0;
      sel        <= sel_code(IDX_M_U);
      seg        <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      slot_cnt   <= slot_cnt_nxt;
      idx        <= idx_nxt;
      shadow_p   <= shadow_p_nxt;
      shadow_m   <= shadow_m_nxt;
      act_p      <= act_p_nxt;
      act_m      <= act_m_nxt;
      blink_cnt  <= blink_cnt_nxt;
      blink_hide <= blink_hide_nxt;
      sel        <= sel_nxt;
      seg        <= seg_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  always_comb begin
    slot_cnt_nxt   = slot_cnt + SLOT_W'(1);
    idx_nxt        = idx;
    shadow_p_nxt   = shadow_p;
    shadow_m_nxt   = shadow_m;
    act_p_nxt      = act_p;
    act_m_nxt      = act_m;
    blink_cnt_nxt  = blink_cnt + BLINK_W'(1);
    blink_hide_nxt = blink_hide;
    sel_nxt        = sel_code(idx);
    frame_done_nxt = 1'b0;

    slot_end = (slot_cnt == SLOT_LAST);
    wrap     = slot_end && (idx == IDX_P_T);

    if (slot_end) begin
      slot_cnt_nxt = '0;
      idx_nxt      = next_idx(idx);
    end

    if (load) begin
      shadow_p_nxt = p_cnt;
      shadow_m_nxt = m_cnt;
    end

    // A load coinciding with the wrap goes straight to the display.
    if (wrap) begin
      act_p_nxt = load ? p_cnt : shadow_p;
      act_m_nxt = load ? m_cnt : shadow_m;
    end

    // Registered so the pulse lands in the wrap cycle itself.
    frame_done_nxt = (slot_cnt == SLOT_PRE) && (idx == IDX_P_T);

    if (blink_cnt == BLINK_LAST) begin
      blink_cnt_nxt  = '0;
      blink_hide_nxt = !blink_hide;
    end

    pair_p     = (idx == IDX_P_U) || (idx == IDX_P_T);
    is_tens    = (idx == IDX_M_T) || (idx == IDX_P_T);
    pair_ovf   = pair_p ? p_ovf : m_ovf;
    pair_blink = pair_p ? blink_p : blink_m;
    if (pair_p) begin
      digit = is_tens ? p_tens : p_units;
    end else begin
      digit = is_tens ? m_tens : m_units;
    end

    // Blanking priority: dead time, blink, overflow dash, leading zero.
    seg_nxt = digit_code(digit);
    if (slot_cnt > DEAD_START) begin
      seg_nxt = SEG_BLANK;
    end else if (pair_blink && blink_hide) begin
      seg_nxt = SEG_BLANK;
    end else if (pair_ovf) begin
      seg_nxt = SEG_DASH;
    end else if (blank_lz && is_tens && (digit == DIG_W'(0))) begin
      seg_nxt = SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: cycle-indexed reference model plus directed table and corner sequences.
module tb_seg_scan_driver;

  localparam int unsigned T_CNT_DIS   = 9;
  localparam int unsigned T_DEAD      = 2;
  localparam int unsigned T_CNT_BLINK = 99;
  localparam int SLOT  = T_CNT_DIS + 1;
  localparam int FRAME = 4 * SLOT;
  localparam int BHALF = T_CNT_BLINK + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] p_cnt = '0;
  logic [5:0] m_cnt = '0;
  logic       load = 1'b0;
  logic       blink_p = 1'b0;
  logic       blink_m = 1'b0;
  logic       blank_lz = 1'b0;
  logic [7:0] sel;
  logic [7:0] seg;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_driver #(
    .CNT_DIS   (T_CNT_DIS),
    .DEAD      (T_DEAD),
    .CNT_BLINK (T_CNT_BLINK)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .p_cnt      (p_cnt),
    .m_cnt      (m_cnt),
    .load       (load),
    .blink_p    (blink_p),
    .blink_m    (blink_m),
    .blank_lz   (blank_lz),
    .sel        (sel),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_code(input int d);
    logic [7:0] codes [10];
    codes = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    return codes[d];
  endfunction

  // Slot position within the frame: 0 m units, 1 m tens, 2 p units, 3 p tens.
  function automatic logic [7:0] ref_sel(input int n);
    int pos;
    pos = (n / SLOT) % 4;
    case (pos)
      0:       return 8'h01;
      1:       return 8'h02;
      2:       return 8'h40;
      default: return 8'h80;
    endcase
  endfunction

  function automatic logic [7:0] ref_seg(input int n, input int ap, input int am,
                                         input bit bp, input bit bm, input bit lz);
    int pos, in_slot, v, d;
    bit hidden, blink, tens;
    in_slot = n % SLOT;
    pos     = (n / SLOT) % 4;
    hidden  = ((n / BHALF) % 2) == 1;
    v       = (pos >= 2) ? ap : am;
    blink   = (pos >= 2) ? bp : bm;
    tens    = (pos == 1) || (pos == 3);
    if (in_slot > int'(T_CNT_DIS - T_DEAD)) return 8'h00;
    if (blink && hidden) return 8'h00;
    if (v >= 60) return 8'h40;
    d = tens ? v / 10 : v % 10;
    if (tens && lz && d == 0) return 8'h00;
    return ref_code(d);
  endfunction

  int         n = 0;
  int         sh_p = 0, sh_m = 0, ac_p = 0, ac_m = 0;
  logic [7:0] exp_sel = 8'h01;
  logic [7:0] exp_seg = 8'h00;
  logic       exp_fd = 1'b0;

  // n counts cycles since reset release; outputs lag the state by one cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; sh_p = 0; sh_m = 0; ac_p = 0; ac_m = 0;
      exp_sel = 8'h01; exp_seg = 8'h00; exp_fd = 1'b0;
    end else begin
      exp_sel = ref_sel(n);
      exp_seg = ref_seg(n, ac_p, ac_m, blink_p, blink_m, blank_lz);
      exp_fd  = ((n + 1) % FRAME) == (FRAME - 1);
      if ((n % FRAME) == FRAME - 1) begin
        ac_p = load ? int'(p_cnt) : sh_p;
        ac_m = load ? int'(m_cnt) : sh_m;
      end
      if (load) begin
        sh_p = int'(p_cnt);
        sh_m = int'(m_cnt);
      end
      n++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (sel !== exp_sel || seg !== exp_seg || frame_done !== exp_fd) begin
        errors++;
        $display("FAIL model n=%0d sel=%h exp %h seg=%h exp %h fd=%b exp %b",
                 n, sel, exp_sel, seg, exp_seg, frame_done, exp_fd);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_fd(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!frame_done && cyc < 200);
    if (!frame_done) begin
      checks++;
      errors++;
      $display("FAIL wait_fd timeout got %0d cycles expected pulse", cyc);
    end
  endtask

  // Wait for the slot with enable s, then sample seg mid-slot.
  task automatic seg_at(input logic [7:0] s, output logic [7:0] v);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (sel !== s && k < 100);
    if (sel !== s) begin
      checks++;
      errors++;
      $display("FAIL seg_at timeout sel=%h expected %h", sel, s);
    end
    repeat (3) @(negedge clk);
    v = seg;
  endtask

  task automatic load_frame(input int p, input int m);
    int c;
    p_cnt = 6'(p);
    m_cnt = 6'(m);
    wait_fd(c);
    repeat (5) @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_fd(c);
  endtask

  typedef struct {
    int         p;
    int         m;
    bit         lz;
    logic [7:0] e_mu;
    logic [7:0] e_mt;
    logic [7:0] e_pu;
    logic [7:0] e_pt;
  } vec_t;

  // ---------------- main sequence ----------------
  initial begin
    vec_t       tbl [6];
    logic [7:0] v, v2;
    int         c, vis, hid;

    tbl[0] = '{p: 35, m: 15, lz: 1'b0, e_mu: 8'h6D, e_mt: 8'h06, e_pu: 8'h6D, e_pt: 8'h4F};
    tbl[1] = '{p: 0,  m: 5,  lz: 1'b1, e_mu: 8'h6D, e_mt: 8'h00, e_pu: 8'h3F, e_pt: 8'h00};
    tbl[2] = '{p: 62, m: 5,  lz: 1'b1, e_mu: 8'h6D, e_mt: 8'h00, e_pu: 8'h40, e_pt: 8'h40};
    tbl[3] = '{p: 20, m: 59, lz: 1'b0, e_mu: 8'h6F, e_mt: 8'h6D, e_pu: 8'h3F, e_pt: 8'h5B};
    tbl[4] = '{p: 9,  m: 63, lz: 1'b0, e_mu: 8'h40, e_mt: 8'h40, e_pu: 8'h6F, e_pt: 8'h3F};
    tbl[5] = '{p: 10, m: 0,  lz: 1'b1, e_mu: 8'h3F, e_mt: 8'h00, e_pu: 8'h3F, e_pt: 8'h06};

    // Reset values while held
    repeat (3) @(negedge clk);
    chk("rst_sel", sel, 8'h01);
    chk("rst_seg", seg, 8'h00);
    chk("rst_fd", 8'(frame_done), 8'h00);
    rst_n = 1'b1;

    // Frame period
    wait_fd(c);
    wait_fd(c);
    chk("fd_period", 8'(c), 8'(FRAME));

    // Old (zero) values remain until the frame after the load
    p_cnt = 6'd35;
    m_cnt = 6'd15;
    repeat (7) @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    seg_at(8'h80, v);
    chk("pre_wrap_old", v, 8'h3F);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      blank_lz = tbl[i].lz;
      load_frame(tbl[i].p, tbl[i].m);
      seg_at(8'h01, v); chk($sformatf("tbl%0d_mu", i), v, tbl[i].e_mu);
      seg_at(8'h02, v); chk($sformatf("tbl%0d_mt", i), v, tbl[i].e_mt);
      seg_at(8'h40, v); chk($sformatf("tbl%0d_pu", i), v, tbl[i].e_pu);
      seg_at(8'h80, v); chk($sformatf("tbl%0d_pt", i), v, tbl[i].e_pt);
    end

    // Dead time: last two cycles of a slot blank
    seg_at(8'h01, v);
    repeat (4) @(negedge clk);
    chk("dead_before", seg, 8'h3F);
    @(negedge clk);
    chk("dead_first", seg, 8'h00);
    @(negedge clk);
    chk("dead_last", seg, 8'h00);

    // Blink on main pair; pedestrian pair stays visible
    blank_lz = 1'b0;
    load_frame(35, 15);
    blink_m = 1'b1;
    vis = 0;
    hid = 0;
    for (int f = 0; f < 12; f++) begin
      seg_at(8'h01, v);
      if (v == 8'h6D) vis++;
      if (v == 8'h00) hid++;
      seg_at(8'h40, v2);
      chk("blink_p_visible", v2, 8'h6D);
    end
    chk("blink_m_both_phases", 8'({vis > 0, hid > 0}), 8'h03);
    for (int f = 0; f < 10; f++) begin
      seg_at(8'h01, v);
      if (v == 8'h00) break;
    end
    chk("blink_m_hidden", v, 8'h00);
    blink_m = 1'b0;
    seg_at(8'h02, v);
    chk("blink_drop", v, 8'h06);

    // Load in the wrap cycle bypasses the shadow
    p_cnt = 6'd20;
    wait_fd(c);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    seg_at(8'h40, v);
    chk("bypass_pu", v, 8'h3F);
    seg_at(8'h80, v);
    chk("bypass_pt", v, 8'h5B);

    // Asynchronous reset mid-slot, between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel", sel, 8'h01);
    chk("arst_seg", seg, 8'h00);
    chk("arst_fd", 8'(frame_done), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      load = 1'b0;
      if ($urandom_range(0, 11) == 0) begin
        p_cnt = 6'($urandom_range(0, 63));
        m_cnt = 6'($urandom_range(0, 63));
        load  = 1'b1;
      end
      if ($urandom_range(0, 149) == 0) blink_p = ~blink_p;
      if ($urandom_range(0, 149) == 0) blink_m = ~blink_m;
      if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
    end
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
